// File: rtl/pl_pkg.sv
// Shared encodings for the pipeline hazard controller: result-select and
// forwarding-select codes, the mul/div hold FSM state type, and the
// forwarding-select helper used for both ALU operands.
package pl_pkg;

  // Result-select codes carried in ResultSrcE
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // ALU operand forwarding selects
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Multi-cycle mul/div hold FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } pl_state_e;

  // The younger producer (M) shadows the older one (W); x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m,
                                         input logic       we_m,
                                         input logic [4:0] rd_w,
                                         input logic       we_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pl_sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module pl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: advance only while below the all-ones ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pl_hazard_ctrl.sv
// Pipeline hazard controller: EX-stage forwarding selects, load-use stalls,
// branch/jump flushes, multi-cycle mul/div holds and stall/flush counters.
//
// Mul/div handshake: MdStartE marks a valid mul/div op sitting in E; MdDoneE
// marks its result valid in the current cycle. The pipeline is held from the
// start cycle up to, but not including, the done cycle. A start accompanied by
// done in the same cycle completes without any hold. MdStartE is ignored while
// an op is already in flight.
module pl_hazard_ctrl
  import pl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             MdStartE,
  input  logic             MdDoneE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output pl_state_e        state_dbg_o
);

  pl_state_e state_q;
  pl_state_e state_d;
  logic      lw_stall;
  logic      md_hold;

  // Hazard detection and control outputs; reset forces bubbles everywhere
  always_comb begin
    lw_stall = (ResultSrcE == RES_MEM) && (RdE != 5'd0) &&
               ((RdE == Rs1D) || (RdE == Rs2D));
    md_hold  = ((state_q == ST_IDLE) && MdStartE && !MdDoneE) ||
               ((state_q == ST_BUSY) && !MdDoneE);
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushM    = 1'b1;
    if (rst_n) begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      // A taken branch squashes the load consumer, so no stall is needed;
      // a mul/div hold freezes everything and overrides both.
      StallF    = md_hold | (lw_stall & ~PCSrcE);
      StallD    = md_hold | (lw_stall & ~PCSrcE);
      StallE    = md_hold;
      FlushM    = md_hold;
      FlushD    = PCSrcE & ~md_hold;
      FlushE    = (lw_stall | PCSrcE) & ~md_hold;
    end
  end

  // Mul/div FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (MdStartE && !MdDoneE) state_d = ST_BUSY;
      ST_BUSY: if (MdDoneE)              state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // Mul/div FSM state register; reset abandons any op in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_dbg_o = state_q;

  pl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (StallD),
    .cnt   (StallCnt)
  );

  pl_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (FlushD),
    .cnt   (FlushCnt)
  );

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed bench for pl_hazard_ctrl with a 4-bit counter build so that
// saturation is reachable quickly.
module tb_pl_hazard_ctrl;
  import pl_pkg::*;

  localparam int CNT_W = 4;
  localparam int SB_W  = 10 + 2*CNT_W + 1;

  // Expected control-output vectors {FwdA, FwdB, StallF, StallD, StallE, FlushD, FlushE, FlushM}
  localparam logic [9:0] O_NONE = 10'b00_00_000_000;
  localparam logic [9:0] O_RST  = 10'b00_00_000_111;
  localparam logic [9:0] O_LW   = 10'b00_00_110_010;
  localparam logic [9:0] O_BR   = 10'b00_00_000_110;
  localparam logic [9:0] O_MD   = 10'b00_00_111_001;

  // clock/reset block
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, RegWriteM, RegWriteW, MdStartE, MdDoneE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [CNT_W-1:0] StallCnt, FlushCnt;
  pl_state_e        state_dbg;

  pl_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .RdM        (RdM),
    .RegWriteM  (RegWriteM),
    .RdW        (RdW),
    .RegWriteW  (RegWriteW),
    .MdStartE   (MdStartE),
    .MdDoneE    (MdDoneE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushM     (FlushM),
    .StallCnt   (StallCnt),
    .FlushCnt   (FlushCnt),
    .state_dbg_o(state_dbg)
  );

  // scoreboard: {outputs, StallCnt, FlushCnt, state}
  logic [SB_W-1:0]  exp_q[$];
  logic [CNT_W-1:0] m_scnt = '0;
  logic [CNT_W-1:0] m_fcnt = '0;
  int               n_checks = 0;
  int               n_errors = 0;

  // driver tasks
  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = RES_ALU; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MdStartE = 1'b0; MdDoneE = 1'b0;
  endtask

  // One clock cycle: push the expectation, compare mid-cycle, then advance the
  // counter model on the edge using the expected StallD/FlushD.
  task automatic cycle(input string tag, input logic [9:0] eo, input logic es);
    logic [SB_W-1:0] obs;
    logic [SB_W-1:0] e;
    exp_q.push_back({eo, m_scnt, m_fcnt, es});
    @(negedge clk);
    obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
           StallCnt, FlushCnt, state_dbg};
    e = exp_q.pop_front();
    n_checks++;
    assert (obs === e) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b (out|scnt|fcnt|st)", tag, obs, e);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_scnt = '0;
      m_fcnt = '0;
    end else begin
      if (eo[4] && (m_scnt != {CNT_W{1'b1}})) m_scnt = m_scnt + 1'b1;
      if (eo[2] && (m_fcnt != {CNT_W{1'b1}})) m_fcnt = m_fcnt + 1'b1;
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;

    // reset state, including forwarding suppressed while in reset
    cycle("rst_idle", O_RST, ST_IDLE);
    RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; PCSrcE = 1'b1;
    cycle("rst_fwd_masked", O_RST, ST_IDLE);
    clear_inputs();
    rst_n = 1'b1;
    cycle("post_rst_quiet", O_NONE, ST_IDLE);

    // forwarding
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
    cycle("fwd_m_over_w", {FWD_M, FWD_RF, 6'b0}, ST_IDLE);
    RegWriteM = 1'b0; Rs2E = 5'd5;
    cycle("fwd_w_both", {FWD_W, FWD_W, 6'b0}, ST_IDLE);
    RegWriteM = 1'b1; RdM = 5'd9; Rs2E = 5'd9;
    cycle("fwd_split", {FWD_W, FWD_M, 6'b0}, ST_IDLE);
    RdM = '0; RdW = '0; Rs1E = '0; Rs2E = '0;
    cycle("fwd_x0", O_NONE, ST_IDLE);
    clear_inputs();

    // load-use stall, one cycle
    ResultSrcE = RES_MEM; RdE = 5'd7; Rs2D = 5'd7;
    cycle("lw_stall", O_LW, ST_IDLE);
    RdE = 5'd0; Rs2D = 5'd0;
    cycle("lw_rd_x0", O_NONE, ST_IDLE);
    ResultSrcE = RES_PC4; RdE = 5'd7; Rs1D = 5'd7;
    cycle("non_load_no_stall", O_NONE, ST_IDLE);
    clear_inputs();

    // branch beats load-use
    ResultSrcE = RES_MEM; RdE = 5'd3; Rs1D = 5'd3; PCSrcE = 1'b1;
    cycle("br_over_lw", O_BR, ST_IDLE);
    clear_inputs();
    cycle("after_br", O_NONE, ST_IDLE);

    // mul/div: start at cycle 0, done at cycle 3
    MdStartE = 1'b1;
    cycle("md_c0", O_MD, ST_IDLE);
    RdM = 5'd4; RegWriteM = 1'b1; Rs1E = 5'd4;
    cycle("md_c1_fwd", {FWD_M, FWD_RF, O_MD[5:0]}, ST_BUSY);
    RegWriteM = 1'b0; PCSrcE = 1'b1;
    cycle("md_c2_br_masked", O_MD, ST_BUSY);
    PCSrcE = 1'b0; MdDoneE = 1'b1;
    cycle("md_c3_done", O_NONE, ST_BUSY);
    clear_inputs();
    cycle("md_c4_idle", O_NONE, ST_IDLE);

    // start and done together: no hold
    MdStartE = 1'b1; MdDoneE = 1'b1;
    cycle("md_same_cycle", O_NONE, ST_IDLE);
    clear_inputs();
    cycle("md_same_after", O_NONE, ST_IDLE);

    // reset in the middle of a mul/div op
    MdStartE = 1'b1;
    cycle("mdr_c0", O_MD, ST_IDLE);
    cycle("mdr_c1", O_MD, ST_BUSY);
    rst_n = 1'b0;
    cycle("mdr_rst", O_RST, ST_BUSY);
    rst_n = 1'b1; MdStartE = 1'b0;
    cycle("mdr_idle", O_NONE, ST_IDLE);

    // stall counter saturation: StallD held 20 cycles
    ResultSrcE = RES_MEM; RdE = 5'd12; Rs1D = 5'd12;
    for (int i = 0; i < 20; i++) begin
      cycle($sformatf("sat_%0d", i), O_LW, ST_IDLE);
    end
    clear_inputs();
    cycle("sat_hold", O_NONE, ST_IDLE);

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
